// File: rtl/axi_lite_regbank_slave.sv
// AXI4-Lite register bank: CTRL/SCRATCH read-write, STATUS sampled from fabric, sticky W1C IRQ.
// Write address and write data are buffered independently; unmapped word slots answer SLVERR.
module axi_lite_regbank_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] CTRL_RESET         = 32'h0000_0000
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [31:0]                     status_in,
  input  logic [3:0]                      irq_event,
  output logic [31:0]                     ctrl_out,
  output logic                            irq_out
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic        out_of_reset;
  logic        aw_full;
  logic [2:0]  aw_slot;
  logic        w_full;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        rvalid;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic [31:0] ctrl;
  logic [31:0] scratch;
  logic [3:0]  irq;
  logic        irq_q;
  logic        commit;
  logic [3:0]  irq_clear;
  logic [31:0] rd_word;
  logic        rd_err;
  logic        unused_ok;

  // Readies stay low for the cycle after reset so nothing is accepted mid-reset.
  assign S_AXI_AWREADY = out_of_reset & ~aw_full & ~bvalid;
  assign S_AXI_WREADY  = out_of_reset & ~w_full & ~bvalid;
  assign S_AXI_ARREADY = out_of_reset & ~rvalid;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RRESP   = rresp;
  assign S_AXI_RDATA   = rdata;
  assign ctrl_out      = ctrl;
  assign irq_out       = irq_q;

  assign commit    = aw_full & w_full;
  assign irq_clear = (commit && aw_slot == 3'd3 && w_strb[0]) ? w_data[3:0] : 4'b0000;
  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      out_of_reset <= 1'b0;
      aw_full      <= 1'b0;
      aw_slot      <= '0;
      w_full       <= 1'b0;
      w_data       <= '0;
      w_strb       <= '0;
      bvalid       <= 1'b0;
      bresp        <= RESP_OKAY;
    end else begin
      out_of_reset <= 1'b1;
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_full <= 1'b1;
        aw_slot <= S_AXI_AWADDR[4:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      // Both buffers can only be full while no response is pending.
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= aw_slot[2] ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid && S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl    <= CTRL_RESET;
      scratch <= '0;
      irq     <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (commit && aw_slot == 3'd0) ctrl <= merge_bytes(ctrl, w_data, w_strb);
      if (commit && aw_slot == 3'd1) scratch <= merge_bytes(scratch, w_data, w_strb);
      irq   <= irq_event | (irq & ~irq_clear);
      irq_q <= |irq;
    end
  end

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    case (S_AXI_ARADDR[4:2])
      3'd0:    rd_word = ctrl;
      3'd1:    rd_word = scratch;
      3'd2:    rd_word = status_in;
      3'd3:    rd_word = {28'b0, irq};
      default: rd_err  = 1'b1;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid <= 1'b0;
      rresp  <= RESP_OKAY;
      rdata  <= '0;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      rvalid <= 1'b1;
      rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      rdata  <= rd_word;
    end else if (rvalid && S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_regbank_slave.sv
// Directed self-checking bench for axi_lite_regbank_slave with hand-computed expectations.
module tb_axi_lite_regbank_slave;

  logic        aclk;
  logic        areset;
  logic [4:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] status_in;
  logic [3:0]  irq_event;
  logic [31:0] ctrl_out;
  logic        irq_out;

  int checks = 0;
  int errors = 0;

  logic [1:0]  resp;
  logic [31:0] data;

  axi_lite_regbank_slave dut (
    .ACLK          (aclk),
    .ARESET        (areset),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (3'b000),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (3'b000),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .status_in     (status_in),
    .irq_event     (irq_event),
    .ctrl_out      (ctrl_out),
    .irq_out       (irq_out)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // One-cycle pulse on the sideband event inputs.
  task automatic applyStimulus(input logic [3:0] events);
    @(posedge aclk); #1;
    irq_event = events;
    @(posedge aclk); #1;
    irq_event = 4'b0000;
  endtask

  task automatic writeWord(input logic [4:0] addr, input logic [31:0] value,
                           input logic [3:0] strb, output logic [1:0] wr_resp);
    bit aw_done, w_done, aw_hs, w_hs, b_done;
    int n;
    awaddr = addr; awvalid = 1'b1;
    wdata = value; wstrb = strb; wvalid = 1'b1;
    bready = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge aclk);
      aw_hs = awvalid & awready;
      w_hs  = wvalid & wready;
      @(posedge aclk); #1;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("wr_accept", {30'b0, aw_done, w_done}, 32'd3);
    b_done = 0; n = 0; wr_resp = 2'b11;
    while (!b_done && n < 20) begin
      @(negedge aclk);
      if (bvalid) begin wr_resp = bresp; b_done = 1; end
      @(posedge aclk); #1;
      n++;
    end
    checkOutput("wr_bvalid", {31'b0, b_done}, 32'd1);
  endtask

  task automatic readWord(input logic [4:0] addr, output logic [31:0] rd_value, output logic [1:0] rd_resp);
    bit ar_hs, done;
    int n;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    done = 0; n = 0;
    while (!done && n < 20) begin
      @(negedge aclk);
      ar_hs = arvalid & arready;
      @(posedge aclk); #1;
      if (ar_hs) done = 1;
      n++;
    end
    arvalid = 1'b0;
    checkOutput("rd_accept", {31'b0, done}, 32'd1);
    done = 0; n = 0; rd_value = 32'hXXXX_XXXX; rd_resp = 2'b11;
    while (!done && n < 20) begin
      @(negedge aclk);
      if (rvalid) begin rd_value = rdata; rd_resp = rresp; done = 1; end
      @(posedge aclk); #1;
      n++;
    end
    checkOutput("rd_rvalid", {31'b0, done}, 32'd1);
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    status_in = 32'hA5A5_0000; irq_event = 4'b0000;

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    checkOutput("rst_awready", {31'b0, awready}, 32'd0);
    checkOutput("rst_wready",  {31'b0, wready},  32'd0);
    checkOutput("rst_arready", {31'b0, arready}, 32'd0);
    checkOutput("rst_bvalid",  {31'b0, bvalid},  32'd0);
    checkOutput("rst_rvalid",  {31'b0, rvalid},  32'd0);
    checkOutput("rst_bresp",   {30'b0, bresp},   32'd0);
    checkOutput("rst_rresp",   {30'b0, rresp},   32'd0);
    checkOutput("rst_rdata",   rdata,            32'd0);
    checkOutput("rst_ctrl",    ctrl_out,         32'd0);
    checkOutput("rst_irq_out", {31'b0, irq_out}, 32'd0);
    areset = 1'b0;
    @(posedge aclk); #1;

    // Sequential writes and readback
    for (int i = 0; i < 4; i++) begin
      writeWord(5'(4 * i), 32'(i + 1), 4'hF, resp);
      checkOutput("t1_bresp", {30'b0, resp}, 32'd0);
    end
    checkOutput("t1_ctrl_out", ctrl_out, 32'd1);
    readWord(5'h00, data, resp);
    checkOutput("t1_rd_ctrl", data, 32'd1);
    checkOutput("t1_rresp", {30'b0, resp}, 32'd0);
    readWord(5'h04, data, resp);
    checkOutput("t1_rd_scratch", data, 32'd2);
    checkOutput("t1_rresp", {30'b0, resp}, 32'd0);
    readWord(5'h08, data, resp);
    checkOutput("t1_rd_status", data, 32'hA5A5_0000);
    checkOutput("t1_rresp", {30'b0, resp}, 32'd0);
    readWord(5'h0C, data, resp);
    checkOutput("t1_rd_irq", data, 32'd0);
    checkOutput("t1_rresp", {30'b0, resp}, 32'd0);

    // W three cycles ahead of AW, partial strobes over zero
    writeWord(5'h04, 32'h0, 4'hF, resp);
    bready = 1'b0;
    @(posedge aclk); #1;
    wdata = 32'hDEAD_BEEF; wstrb = 4'b0101; wvalid = 1'b1;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    checkOutput("t2_wready_full", {31'b0, wready}, 32'd0);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    awaddr = 5'h04; awvalid = 1'b1;
    checkOutput("t2_bvalid_early", {31'b0, bvalid}, 32'd0);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    checkOutput("t2_bvalid_n", {31'b0, bvalid}, 32'd0);
    @(posedge aclk); #1;
    checkOutput("t2_bvalid_n1", {31'b0, bvalid}, 32'd1);
    checkOutput("t2_bresp", {30'b0, bresp}, 32'd0);
    bready = 1'b1;
    @(posedge aclk); #1;
    readWord(5'h04, data, resp);
    checkOutput("t2_scratch", data, 32'h00AD_00EF);

    // Unmapped slots
    writeWord(5'h14, 32'h1234, 4'hF, resp);
    checkOutput("t3_bresp", {30'b0, resp}, 32'd2);
    readWord(5'h1C, data, resp);
    checkOutput("t3_rresp", {30'b0, resp}, 32'd2);
    checkOutput("t3_rdata", data, 32'd0);
    readWord(5'h00, data, resp);
    checkOutput("t3_ctrl", data, 32'd1);
    readWord(5'h04, data, resp);
    checkOutput("t3_scratch", data, 32'h00AD_00EF);
    readWord(5'h0C, data, resp);
    checkOutput("t3_irq", data, 32'd0);

    // IRQ set, clear racing an event, full clear
    applyStimulus(4'b0110);
    readWord(5'h0C, data, resp);
    checkOutput("t4_irq_set", data, 32'd6);
    checkOutput("t4_irq_out_set", {31'b0, irq_out}, 32'd1);
    @(posedge aclk); #1;
    awaddr = 5'h0C; awvalid = 1'b1; wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; irq_event = 4'b0010;
    checkOutput("t4_bvalid_pre", {31'b0, bvalid}, 32'd0);
    @(posedge aclk); #1;
    irq_event = 4'b0000;
    checkOutput("t4_commit", {31'b0, bvalid}, 32'd1);
    @(posedge aclk); #1;
    readWord(5'h0C, data, resp);
    checkOutput("t4_irq_race", data, 32'd6);
    writeWord(5'h0C, 32'h6, 4'hF, resp);
    readWord(5'h0C, data, resp);
    checkOutput("t4_irq_clr", data, 32'd0);
    checkOutput("t4_irq_out_clr", {31'b0, irq_out}, 32'd0);

    // Backpressure on both response channels
    bready = 1'b0; rready = 1'b0;
    @(posedge aclk); #1;
    awaddr = 5'h04; awvalid = 1'b1; wdata = 32'h5555_AAAA; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 5'h00; arvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge aclk); #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t5_bvalid", {31'b0, bvalid}, 32'd1);
      checkOutput("t5_rvalid", {31'b0, rvalid}, 32'd1);
      checkOutput("t5_bresp", {30'b0, bresp}, 32'd0);
      checkOutput("t5_rdata", rdata, 32'd1);
      checkOutput("t5_readies", {29'b0, awready, wready, arready}, 32'd0);
      @(posedge aclk); #1;
    end
    bready = 1'b1; rready = 1'b1;
    @(posedge aclk); #1;
    checkOutput("t5_released", {28'b0, bvalid, rvalid, awready, arready}, 32'd3);
    readWord(5'h04, data, resp);
    checkOutput("t5_scratch", data, 32'h5555_AAAA);

    // Reset with AW buffered and W pending
    @(posedge aclk); #1;
    awaddr = 5'h00; awvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    checkOutput("t6_valids", {30'b0, bvalid, rvalid}, 32'd0);
    checkOutput("t6_readies", {29'b0, awready, wready, arready}, 32'd0);
    checkOutput("t6_ctrl", ctrl_out, 32'd0);
    @(posedge aclk); #1;
    wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    checkOutput("t6_w_held", {31'b0, wready}, 32'd0);
    repeat (4) @(posedge aclk);
    #1;
    checkOutput("t6_no_bvalid", {31'b0, bvalid}, 32'd0);
    checkOutput("t6_ctrl_kept", ctrl_out, 32'd0);
    readWord(5'h00, data, resp);
    checkOutput("t6_rd_ctrl", data, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_regbank_slave.md
Name: axi_lite_regbank_slave

Overview:
AXI4-Lite responder (slave) register bank for the AXI-Lite control path, driven by the master VIP or the PS GP port. It exposes four 32-bit registers: CTRL (RW), SCRATCH (RW), STATUS (RO, sampled from fabric) and IRQ (sticky, write-1-to-clear). Write address and write data are buffered independently, and out-of-range accesses return SLVERR.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word slots, of which slots 0-3 are implemented.
CTRL_RESET, 32'h0000_0000, reset value of CTRL.

Ports:
ACLK  in  1  clock; all logic rising-edge.
ARESET  in  1  synchronous, active-high reset.
S_AXI_AWADDR  in  5  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake.
S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake.
S_AXI_ARADDR  in  5  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake.
status_in  in  32  live status; read through STATUS.
irq_event  in  4  one pulse per bit per event; sets IRQ[3:0].
ctrl_out  out  32  current CTRL value.
irq_out  out  1  OR of IRQ[3:0].

Behaviour:
- Reset (ARESET=1 at a clock edge) produces: all READY and VALID outputs 0; BRESP and RRESP 00; RDATA 0; CTRL=CTRL_RESET; SCRATCH=0; IRQ=0; irq_out=0. Reset mid-transaction discards any buffered AW, W or pending response.
- Register map, selected by addr[4:2]:
  - 0: CTRL, RW.
  - 1: SCRATCH, RW.
  - 2: STATUS, RO. Writes are ignored but return OKAY.
  - 3: IRQ, W1C on bits [3:0]; bits [31:4] read 0.
  - 4-7: unmapped. Writes and reads both return SLVERR, writes have no effect, and reads return data 0.
- addr[1:0] is ignored.
- Write path:
  - AWREADY=1 while the AW buffer is empty and BVALID=0. WREADY follows the same rule with the W buffer.
  - AW and W are captured independently, in any order or in the same cycle.
  - In the cycle after both buffers are full, the register is updated per WSTRB byte lanes and BVALID=1 with BRESP set.
  - Both buffers clear on that commit. BVALID holds, with stable BRESP, until BREADY=1.
  - Maximum one outstanding write. Best-case latency is AW+W in cycle N, commit plus BVALID in N+1.
- Read path:
  - ARREADY=1 while RVALID=0.
  - On the AR handshake at cycle N: in N+1, RVALID=1 and RDATA/RRESP are registered.
  - STATUS is sampled at the N edge.
  - RDATA and RRESP stay stable until RREADY=1. ARREADY is 0 while RVALID=1.
- Read and write channels are independent. On a same-cycle read and commit to the same register, the read returns the pre-write value.
- IRQ update, per bit each cycle: IRQ[b] <= irq_event[b] | (IRQ[b] & ~(w1c_commit & WSTRB[0] & WDATA[b])). A simultaneous event and clear leaves the bit set.
- irq_out is registered from IRQ, so it is 1 cycle after the IRQ change.
- No combinational path from any input to any READY or VALID output.

Test Plan:
1. Sequential writes of 1, 2, 3, 4 to 0x0, 0x4, 0x8, 0xC, then read back four words with status_in=32'hA5A5_0000 and IRQ=0 -> reads 1, 2, 32'hA5A5_0000, 0; all BRESP/RRESP=00; ctrl_out=1.
2. W presented 3 cycles before AW on SCRATCH with data 32'hDEAD_BEEF and WSTRB=4'b0101 over 0 -> SCRATCH=32'h00AD_00EF; BVALID exactly 1 cycle after AW is accepted.
3. Write 32'h1234 to 0x14, then read 0x1C -> BRESP=10 and RRESP=10 with RDATA=0; CTRL, SCRATCH and IRQ unchanged.
4. Pulse irq_event=4'b0110 -> IRQ reads 6 and irq_out=1. Write 0x2 to 0xC in the same cycle as an irq_event[1] pulse -> IRQ stays 6. Write 0x6 -> IRQ reads 0 and irq_out=0.
5. Hold BREADY=0 and RREADY=0 for 5 cycles after a write and a read -> BVALID/RVALID stay 1 with stable data, and AWREADY/WREADY/ARREADY stay 0 until the handshake completes.
6. Assert ARESET for one cycle with AW buffered but W not yet seen -> all VALIDs 0, no register update when W later arrives alone, and CTRL=CTRL_RESET.
